// File: rtl/vga_pattern_sched_if.sv
// vga_pattern_sched_if: host pattern-request handshake
// cfg_req/cfg_mode: level request and code from the host, held until cfg_ack
// cfg_ack/cfg_err: one-cycle consume pulse, err marks an out-of-range code
interface vga_pattern_sched_if;
  logic       cfg_req;
  logic [2:0] cfg_mode;
  logic       cfg_ack;
  logic       cfg_err;
  modport master (output cfg_req, cfg_mode, input cfg_ack, cfg_err);
  modport slave (input cfg_req, cfg_mode, output cfg_ack, cfg_err);
endinterface

// File: rtl/vga_pattern_sched.sv
// vga_pattern_sched: frame-synchronous display pattern scheduler
// vga_clk/sys_rst: pixel clock, sync active-high reset
// vga_vs: active-low field sync; auto_en: cycle patterns every DWELL_FRAMES frames
// cfg: host request handshake; pattern_sel/pattern_valid: display stage select
// frame_cnt: frames seen since reset
module vga_pattern_sched #(
  parameter int NUM_PATTERNS = 5,
  parameter int DWELL_FRAMES = 120
) (
  input  logic                      vga_clk,
  input  logic                      sys_rst,
  input  logic                      vga_vs,
  input  logic                      auto_en,
  vga_pattern_sched_if.slave        cfg,
  output logic [2:0]                pattern_sel,
  output logic                      pattern_valid,
  output logic [15:0]               frame_cnt
);
  localparam logic [3:0]  NP      = 4'(NUM_PATTERNS);
  localparam logic [2:0]  LAST    = 3'(NUM_PATTERNS - 1);
  localparam logic [15:0] DW_LAST = 16'(DWELL_FRAMES - 1);
  typedef enum logic [1:0] {WAIT_SYNC, RUN, PEND} state_t;
  state_t      state;
  logic        vs_d;
  logic        req_lat;
  logic [2:0]  mode_lat;
  logic [15:0] dwell;
  logic        frame_start;
  logic        take;
  logic        mode_ok;
  logic        dwell_done;
  logic [2:0]  sel_next;
  assign frame_start = vs_d & ~vga_vs;
  // the cycle right after an ack never starts a new request
  assign take        = cfg.cfg_req & ~cfg.cfg_ack;
  assign mode_ok     = {1'b0, mode_lat} < NP;
  assign dwell_done  = dwell == DW_LAST;
  assign sel_next    = pattern_sel == LAST ? 3'd0 : pattern_sel + 3'd1;
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state         <= WAIT_SYNC;
      vs_d          <= 1'b1;
      req_lat       <= 1'b0;
      mode_lat      <= 3'd0;
      dwell         <= 16'd0;
      pattern_sel   <= 3'd0;
      pattern_valid <= 1'b0;
      frame_cnt     <= 16'd0;
      cfg.cfg_ack   <= 1'b0;
      cfg.cfg_err   <= 1'b0;
    end else begin
      vs_d        <= vga_vs;
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      case (state)
        WAIT_SYNC: begin
          if (take) begin
            req_lat  <= 1'b1;
            mode_lat <= cfg.cfg_mode;
          end
          // a request seen before the first boundary waits for the next one
          if (frame_start) begin
            pattern_valid <= 1'b1;
            dwell         <= 16'd0;
            state         <= (take | req_lat) ? PEND : RUN;
          end
        end
        RUN: begin
          if (frame_start && auto_en) begin
            dwell <= dwell_done ? 16'd0 : dwell + 16'd1;
            if (dwell_done) pattern_sel <= sel_next;
          end
          if (take) begin
            mode_lat <= cfg.cfg_mode;
            state    <= PEND;
          end
        end
        PEND: begin
          // host application pre-empts any auto advance on this boundary
          if (frame_start) begin
            cfg.cfg_ack <= 1'b1;
            cfg.cfg_err <= ~mode_ok;
            if (mode_ok) pattern_sel <= mode_lat;
            dwell <= 16'd0;
            state <= RUN;
          end
        end
        default: state <= WAIT_SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_pattern_sched.sv
// tb_vga_pattern_sched: scoreboard bench for the pattern scheduler
module tb_vga_pattern_sched;
  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        vga_vs  = 1'b1;
  logic        auto_en = 1'b0;
  logic [2:0]  pattern_sel;
  logic        pattern_valid;
  logic [15:0] frame_cnt;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [19:0] frame_q[$];
  logic [3:0]  ack_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [2:0]  seq[12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0};
  vga_pattern_sched_if cfg_if();
  vga_pattern_sched #(.NUM_PATTERNS(5), .DWELL_FRAMES(2)) dut (
    .vga_clk(vga_clk),
    .sys_rst(sys_rst),
    .vga_vs(vga_vs),
    .auto_en(auto_en),
    .cfg(cfg_if),
    .pattern_sel(pattern_sel),
    .pattern_valid(pattern_valid),
    .frame_cnt(frame_cnt)
  );
  always #5 vga_clk = ~vga_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask
  task automatic tick;
    @(posedge vga_clk);
    #1;
    if (cfg_if.cfg_ack) cfg_if.cfg_req = 1'b0;
  endtask
  task automatic frame(input logic [2:0] sel);
    exp_cnt++;
    frame_q.push_back({sel, 1'b1, exp_cnt});
    vga_vs = 1'b0;
    tick;
    tick;
    vga_vs = 1'b1;
    repeat (8) tick;
  endtask
  task automatic do_reset;
    sys_rst = 1'b1;
    repeat (3) tick;
    sys_rst = 1'b0;
    exp_cnt = 16'd0;
    @(negedge vga_clk);
    chk("reset_state", {pattern_sel, pattern_valid, frame_cnt, cfg_if.cfg_ack, cfg_if.cfg_err}, 23'd0);
    tick;
  endtask
  task automatic req(input logic [2:0] m, input logic [3:0] exp_ack, input logic [2:0] hold);
    cfg_if.cfg_mode = m;
    cfg_if.cfg_req  = 1'b1;
    ack_q.push_back(exp_ack);
    repeat (3) tick;
    chk("hold_before_frame", {cfg_if.cfg_ack, pattern_sel}, {1'b0, hold});
  endtask
  initial begin : frame_mon
    logic        pv;
    logic [19:0] e;
    pv = 1'b1;
    forever begin
      @(negedge vga_clk);
      if (!sys_rst && pv && !vga_vs) begin
        @(negedge vga_clk);
        if (frame_q.size() == 0) flag("frame_unexpected");
        else begin
          e = frame_q.pop_front();
          chk("frame_sel_valid_cnt", {pattern_sel, pattern_valid, frame_cnt}, e);
        end
      end
      pv = vga_vs;
    end
  end
  initial begin : ack_mon
    logic       pa;
    logic [3:0] e;
    pa = 1'b0;
    forever begin
      @(negedge vga_clk);
      if (cfg_if.cfg_err && !cfg_if.cfg_ack) flag("err_without_ack");
      if (cfg_if.cfg_ack) begin
        if (pa) flag("ack_consecutive");
        if (ack_q.size() == 0) flag("ack_unexpected");
        else begin
          e = ack_q.pop_front();
          chk("ack_err_sel", {cfg_if.cfg_err, pattern_sel}, e);
        end
      end
      pa = cfg_if.cfg_ack;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    cfg_if.cfg_req  = 1'b0;
    cfg_if.cfg_mode = 3'd0;
    do_reset;
    repeat (3) frame(3'd0);
    do_reset;
    auto_en = 1'b1;
    foreach (seq[i]) frame(seq[i]);
    auto_en = 1'b0;
    req(3'd3, {1'b0, 3'd3}, 3'd0);
    frame(3'd3);
    auto_en = 1'b1;
    frame(3'd3);
    frame(3'd4);
    auto_en = 1'b0;
    req(3'd6, {1'b1, 3'd4}, 3'd4);
    frame(3'd4);
    auto_en = 1'b1;
    frame(3'd4);
    req(3'd2, {1'b0, 3'd2}, 3'd4);
    frame(3'd2);
    frame(3'd2);
    frame(3'd3);
    auto_en = 1'b0;
    req(3'd1, {1'b0, 3'd1}, 3'd3);
    do_reset;
    frame(3'd0);
    frame(3'd1);
    repeat (5) tick;
    chk("frames_left", frame_q.size(), 0);
    chk("acks_left", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pattern_sched.md
VGA_PATTERN_SCHED -- requirements
Module: vga_pattern_sched

Interface
REQ-001 Parameter NUM_PATTERNS, default 5: number of display patterns the display stage implements, with codes 0..NUM_PATTERNS-1.
REQ-002 Parameter DWELL_FRAMES, default 120: frames each pattern is shown in auto mode (range 1..65535).
REQ-003 vga_clk  in  1  pixel clock; all logic on its rising edge.
REQ-004 sys_rst  in  1  reset, synchronous and active-high.
REQ-005 vga_vs  in  1  field sync from the VGA driver, active-low pulse.
REQ-006 auto_en  in  1  high = auto-cycle patterns; low = freeze the current pattern.
REQ-007 cfg_req  in  1  host pattern request, level, held until cfg_ack.
REQ-008 cfg_mode  in  3  requested pattern code, stable while cfg_req is high.
REQ-009 cfg_ack  out  1  one-cycle pulse marking that the request was consumed.
REQ-010 cfg_err  out  1  one-cycle pulse coincident with cfg_ack when cfg_mode >= NUM_PATTERNS.
REQ-011 pattern_sel  out  3  pattern code driven to the display stage.
REQ-012 pattern_valid  out  1  high once the first frame boundary after reset has been seen.
REQ-013 frame_cnt  out  16  frames elapsed since reset, wraps 65535->0.

Function
REQ-014 vs_d SHALL be a registered copy of vga_vs; frame_start = vs_d & ~vga_vs (falling edge), one cycle per frame.
REQ-015 The FSM SHALL have three states: WAIT_SYNC (after reset), RUN, and PEND (host request captured, not yet applied).
REQ-016 WAIT_SYNC -> RUN on frame_start: pattern_valid <= 1, pattern_sel stays 0, dwell counter <= 0; no other outputs change.
REQ-017 In RUN, on a cycle with cfg_req=1 and cfg_ack=0, the FSM SHALL latch cfg_mode and go to PEND; a request is also latched in WAIT_SYNC but is applied only at a frame_start.
REQ-018 Changes to pattern_sel SHALL occur only on the clock edge where frame_start=1 (no mid-frame tearing); the new value is visible one cycle after vga_vs is sampled low.
REQ-019 In PEND at frame_start, the block SHALL pulse cfg_ack, load pattern_sel <= the latched mode if that mode is valid (otherwise pulse cfg_err and leave pattern_sel unchanged), clear the dwell counter, and return to RUN.
REQ-020 When a host application and an auto advance fall on the same frame_start, the host application SHALL win and no auto advance occurs on that frame.
REQ-021 Auto advance: in RUN with auto_en=1, each frame_start increments the 16-bit dwell counter; when it reaches DWELL_FRAMES-1, pattern_sel <= (pattern_sel+1) mod NUM_PATTERNS and dwell <= 0.
REQ-022 With auto_en=0, the dwell counter SHALL hold its value and pattern_sel changes only through host requests.
REQ-023 cfg_ack SHALL never pulse in two consecutive cycles; after an ack, a cfg_req still high on the following cycle counts as a new request.
REQ-024 frame_cnt SHALL increment on every frame_start in every state, including WAIT_SYNC.

Reset
REQ-025 With sys_rst=1 at a clock edge, the block SHALL enter WAIT_SYNC with pattern_sel=0, pattern_valid=0, cfg_ack=0, cfg_err=0, frame_cnt=0, dwell=0, vs_d=1, and any latched request dropped.
REQ-026 A reset asserted mid-frame or in PEND SHALL abort the request without an ack; a cfg_req still high after reset is recaptured as a new request.

Verification
REQ-027 Reset, then 3 frames with auto_en=0 -> pattern_valid rises at the 1st vs falling edge, pattern_sel=0 throughout, frame_cnt=3.
REQ-028 DWELL_FRAMES=2, NUM_PATTERNS=5, auto_en=1, 12 frames -> pattern_sel sequence 0,0,1,1,2,2,3,3,4,4,0,0, each change exactly 1 cycle after a vs falling edge.
REQ-029 cfg_req with cfg_mode=3 raised mid-frame -> cfg_ack one-cycle pulse at the next frame_start, pattern_sel=3, dwell restarts, no change before the boundary.
REQ-030 cfg_mode=6 (invalid) -> cfg_ack and cfg_err pulse together, pattern_sel unchanged.
REQ-031 Host request pending on the frame where the dwell expires -> pattern_sel = requested code, not the auto-advance value.
REQ-032 sys_rst pulsed while in PEND -> no cfg_ack, all outputs at reset values; cfg_req held high -> acked at the 2nd frame_start after reset.
